// File: rtl/vdac_pkg.sv
// Shared constants and types for the VDAC input quantiser.
// The forward DAC maps a 25-level code to level*255/24. The quantiser inverts that curve.
package vdac_pkg;

  // Threshold width and the scale constants of the forward DAC curve (out = level * DAC_NUM / DAC_DEN).
  localparam int TH_W       = 8;
  localparam int DAC_NUM    = 255;
  localparam int DAC_DEN    = 24;
  localparam int LEVELS_25  = 24;
  localparam int LEVELS_LIN = 31;

  // Width of the stage-1 sum: 255*24 + 248 = 6368 fits in 13 bits.
  localparam int SUM_W = 13;

  // Round-to-nearest threshold, used when dithering is off.
  localparam logic [TH_W-1:0] TH_NEAREST = 8'd128;

  // Output scale selected by the mode pin.
  typedef enum logic {
    MODE_25  = 1'b0,
    MODE_LIN = 1'b1
  } qmode_e;

  // Per-pixel control bits that travel down the pipeline beside the colour data.
  typedef struct packed {
    logic valid;
    logic hs;
    logic vs;
  } vctl_t;

  // 4x4 ordered-dither matrix, indexed [y][x].
  localparam logic [3:0] BAYER [4][4] = '{
    '{4'd0,  4'd8,  4'd2,  4'd10},
    '{4'd12, 4'd4,  4'd14, 4'd6 },
    '{4'd3,  4'd11, 4'd1,  4'd9 },
    '{4'd15, 4'd7,  4'd13, 4'd5 }
  };

  // Threshold t = B*16 + 8. Inverting the frame gives 256 - t, which is the same as using 15 - B (bitwise ~B).
  function automatic logic [TH_W-1:0] bayer_threshold(input logic [1:0] x,
                                                      input logic [1:0] y,
                                                      input logic       invert);
    logic [3:0] b;
    b = BAYER[y][x];
    if (invert) b = ~b;
    return {b, 4'b1000};
  endfunction

endpackage

// File: rtl/vdac_quant_ch.sv
// One colour channel of the quantiser.
// Stage 1 registers the scaled sum and the mode. Stage 2 reduces the sum to the output level.
module vdac_quant_ch
  import vdac_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      i_in,
  input  logic [TH_W-1:0] i_t,
  input  qmode_e          i_mode,
  output logic [4:0]      o_q
);

  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] r_sum;
  qmode_e           r_mode;
  logic [4:0]       w_q25;
  logic [4:0]       w_qlin;
  logic [4:0]       w_q;
  logic [4:0]       r_q;

  // Stage-1 sum. The 25-level path scales by 24 and adds the full threshold.
  // The linear path drops 3 LSBs, so it adds only the top 3 threshold bits (0..7). With t=128 this adds half an LSB (4).
  always_comb begin
    if (i_mode == MODE_25) begin
      w_sum = SUM_W'(i_in) * SUM_W'(DAC_DEN) + SUM_W'(i_t);
    end else begin
      w_sum = SUM_W'(i_in) + SUM_W'(i_t >> 5);
    end
  end

  // Stage-1 registers.
  // NOTE: datapath registers are reset as well, so every output reads 0 straight out of reset even when blanking is not clamped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum  <= '0;
      r_mode <= MODE_25;
    end else begin
      r_sum  <= w_sum;
      r_mode <= i_mode;
    end
  end

  // Exact floor(sum/255) by a comparator tree against every multiple of 255.
  // The tree stops at 24, so the clamp is built in.
  // NOTE: every always_comb output gets a default before any conditional assignment, so no latch can be inferred.
  always_comb begin
    w_q25 = '0;
    for (int k = 1; k <= LEVELS_25; k++) begin
      if ({{(32-SUM_W){1'b0}}, r_sum} >= 32'(k * DAC_NUM)) w_q25 = 5'(k);
    end
    // The linear sum is at most 262. Bit 8 set means the level would be 32 or more, so clamp to 31.
    w_qlin = r_sum[8] ? 5'(LEVELS_LIN) : r_sum[7:3];
    w_q    = (r_mode == MODE_25) ? w_q25 : w_qlin;
  end

  // Stage-2 output register.
  // NOTE: sequential state uses non-blocking assignments so that all registers update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= '0;
    else     r_q <= w_q;
  end

  assign o_q = r_q;

endmodule

// File: rtl/vdac_quant.sv
// Quantises 8-bit RGB to 5-bit levels, with optional 4x4 ordered dither and frame-alternating inversion.
// The module is a fixed 2-stage pipeline. Valid and sync signals are delayed to match the colour data.
module vdac_quant
  import vdac_pkg::*;
#(
  parameter int TEMPORAL    = 1,
  parameter int CLAMP_BLANK = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic       dither_en,
  input  logic       i_valid,
  input  logic       i_hs,
  input  logic       i_vs,
  input  logic [7:0] i_r,
  input  logic [7:0] i_g,
  input  logic [7:0] i_b,
  output logic       o_valid,
  output logic       o_hs,
  output logic       o_vs,
  output logic [4:0] o_r,
  output logic [4:0] o_g,
  output logic [4:0] o_b
);

  localparam logic TEMPORAL_EN = logic'(TEMPORAL != 0);
  localparam logic CLAMP_EN    = logic'(CLAMP_BLANK != 0);

  logic            r_hs_prev;
  logic            r_vs_prev;
  logic [1:0]      r_x;
  logic [1:0]      r_y;
  logic            r_par;
  logic            w_hs_rise;
  logic            w_vs_rise;
  logic [1:0]      w_x_pix;
  logic [1:0]      w_y_pix;
  logic [1:0]      w_x_next;
  logic            w_par_pix;
  logic [TH_W-1:0] w_t;
  vctl_t           w_ctl_in;
  vctl_t           r_ctl1;
  vctl_t           r_ctl2;
  logic [4:0]      w_q_r;
  logic [4:0]      w_q_g;
  logic [4:0]      w_q_b;

  // Pixel position in the dither tile.
  // Sync edges are applied before the pixel of the same cycle uses the position. A vsync edge overrides an hsync edge.
  always_comb begin
    w_hs_rise = i_hs & ~r_hs_prev;
    w_vs_rise = i_vs & ~r_vs_prev;
    w_x_pix   = r_x;
    w_y_pix   = r_y;
    if (w_vs_rise) begin
      w_x_pix = '0;
      w_y_pix = '0;
    end else if (w_hs_rise) begin
      w_x_pix = '0;
      w_y_pix = r_y + 2'd1;
    end
    w_x_next  = i_valid ? w_x_pix + 2'd1 : w_x_pix;
    w_par_pix = r_par ^ (w_vs_rise & TEMPORAL_EN);
    w_t       = dither_en ? bayer_threshold(w_x_pix, w_y_pix, w_par_pix) : TH_NEAREST;
    w_ctl_in  = '{valid: i_valid, hs: i_hs, vs: i_vs};
  end

  // Sync edge detectors, tile position and frame parity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs_prev <= 1'b0;
      r_vs_prev <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_par     <= 1'b0;
    end else begin
      r_hs_prev <= i_hs;
      r_vs_prev <= i_vs;
      r_x       <= w_x_next;
      r_y       <= w_y_pix;
      r_par     <= w_par_pix;
    end
  end

  // Two-stage delay of valid and syncs, aligned with the channel pipelines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctl1 <= '0;
      r_ctl2 <= '0;
    end else begin
      r_ctl1 <= w_ctl_in;
      r_ctl2 <= r_ctl1;
    end
  end

  vdac_quant_ch u_ch_r (
    .clk    (clk),
    .rst    (rst),
    .i_in   (i_r),
    .i_t    (w_t),
    .i_mode (qmode_e'(mode)),
    .o_q    (w_q_r)
  );

  vdac_quant_ch u_ch_g (
    .clk    (clk),
    .rst    (rst),
    .i_in   (i_g),
    .i_t    (w_t),
    .i_mode (qmode_e'(mode)),
    .o_q    (w_q_g)
  );

  vdac_quant_ch u_ch_b (
    .clk    (clk),
    .rst    (rst),
    .i_in   (i_b),
    .i_t    (w_t),
    .i_mode (qmode_e'(mode)),
    .o_q    (w_q_b)
  );

  assign o_valid = r_ctl2.valid;
  assign o_hs    = r_ctl2.hs;
  assign o_vs    = r_ctl2.vs;
  assign o_r     = (CLAMP_EN && !r_ctl2.valid) ? 5'd0 : w_q_r;
  assign o_g     = (CLAMP_EN && !r_ctl2.valid) ? 5'd0 : w_q_g;
  assign o_b     = (CLAMP_EN && !r_ctl2.valid) ? 5'd0 : w_q_b;

endmodule
